// File: rtl/sc_statemachine_entryfrogger.sv
// Entry-row controller for the frogger game: opens a left/right gap on button
// presses, clears the row while a frog arrives, and times each interval.
module sc_statemachine_entryfrogger #(
  parameter int unsigned SC_STATEMACHINE_ENTRYFROGGER_COUNTWIDTH = 24,
  parameter logic [SC_STATEMACHINE_ENTRYFROGGER_COUNTWIDTH-1:0] OPEN_TICKS  = 24'd5000000,
  parameter logic [SC_STATEMACHINE_ENTRYFROGGER_COUNTWIDTH-1:0] CLEAR_TICKS = 24'd10000000
) (
  input  logic       SC_STATEMACHINE_ENTRYFROGGER_CLOCK_50,
  input  logic       SC_STATEMACHINE_ENTRYFROGGER_RESET_InHigh,
  input  logic       SC_STATEMACHINE_ENTRYFROGGER_start_In,
  input  logic       SC_STATEMACHINE_ENTRYFROGGER_left_In,
  input  logic       SC_STATEMACHINE_ENTRYFROGGER_right_In,
  input  logic       SC_STATEMACHINE_ENTRYFROGGER_arrive_In,
  output logic [1:0] SC_STATEMACHINE_ENTRYFROGGER_loadEntry_OutBUS,
  output logic       SC_STATEMACHINE_ENTRYFROGGER_cleared_Out,
  output logic [2:0] SC_STATEMACHINE_ENTRYFROGGER_state_OutBUS
);

  localparam int unsigned W = SC_STATEMACHINE_ENTRYFROGGER_COUNTWIDTH;
  localparam logic [W-1:0] OPEN_LAST  = OPEN_TICKS - 1'b1;
  localparam logic [W-1:0] CLEAR_LAST = CLEAR_TICKS - 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_NONE  = 3'b001,
    ST_LEFT  = 3'b010,
    ST_RIGHT = 3'b011,
    ST_CLEAR = 3'b100
  } state_t;

  state_t       state;
  logic [W-1:0] timer;
  logic         leftPrev;
  logic         rightPrev;
  logic         leftRise;
  logic         rightRise;

  assign leftRise  = SC_STATEMACHINE_ENTRYFROGGER_left_In  & ~leftPrev;
  assign rightRise = SC_STATEMACHINE_ENTRYFROGGER_right_In & ~rightPrev;

  always_ff @(posedge SC_STATEMACHINE_ENTRYFROGGER_CLOCK_50) begin
    if (SC_STATEMACHINE_ENTRYFROGGER_RESET_InHigh) begin
      state     <= ST_IDLE;
      timer     <= '0;
      leftPrev  <= 1'b0;
      rightPrev <= 1'b0;
    end else begin
      leftPrev  <= SC_STATEMACHINE_ENTRYFROGGER_left_In;
      rightPrev <= SC_STATEMACHINE_ENTRYFROGGER_right_In;
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (SC_STATEMACHINE_ENTRYFROGGER_start_In) state <= ST_NONE;
        end
        ST_NONE: begin
          timer <= '0;
          if (SC_STATEMACHINE_ENTRYFROGGER_arrive_In) state <= ST_CLEAR;
          else if (leftRise && !rightRise)            state <= ST_LEFT;
          else if (rightRise && !leftRise)            state <= ST_RIGHT;
        end
        ST_LEFT, ST_RIGHT: begin
          // Any button rise restarts the gap; simultaneous rises cancel it.
          if (SC_STATEMACHINE_ENTRYFROGGER_arrive_In) begin
            state <= ST_CLEAR;
            timer <= '0;
          end else if (leftRise && rightRise) begin
            state <= ST_NONE;
            timer <= '0;
          end else if (leftRise) begin
            state <= ST_LEFT;
            timer <= '0;
          end else if (rightRise) begin
            state <= ST_RIGHT;
            timer <= '0;
          end else if (timer == OPEN_LAST) begin
            state <= ST_NONE;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_CLEAR: begin
          if (timer == CLEAR_LAST) begin
            state <= ST_NONE;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  always_comb begin
    SC_STATEMACHINE_ENTRYFROGGER_loadEntry_OutBUS = 2'b11;
    SC_STATEMACHINE_ENTRYFROGGER_cleared_Out      = 1'b0;
    SC_STATEMACHINE_ENTRYFROGGER_state_OutBUS     = state;
    case (state)
      ST_IDLE:  SC_STATEMACHINE_ENTRYFROGGER_loadEntry_OutBUS = 2'b11;
      ST_NONE:  SC_STATEMACHINE_ENTRYFROGGER_loadEntry_OutBUS = 2'b00;
      ST_LEFT:  SC_STATEMACHINE_ENTRYFROGGER_loadEntry_OutBUS = 2'b10;
      ST_RIGHT: SC_STATEMACHINE_ENTRYFROGGER_loadEntry_OutBUS = 2'b01;
      ST_CLEAR: begin
        SC_STATEMACHINE_ENTRYFROGGER_loadEntry_OutBUS = 2'b11;
        SC_STATEMACHINE_ENTRYFROGGER_cleared_Out      = (timer == CLEAR_LAST);
      end
      default:  SC_STATEMACHINE_ENTRYFROGGER_loadEntry_OutBUS = 2'b11;
    endcase
  end

endmodule

// File: tb/tb_sc_statemachine_entryfrogger.sv
// Bench for the entry-row controller: directed scenarios with literal
// expectations, then randomized stimulus against a countdown-based model.
module tb_sc_statemachine_entryfrogger;

  localparam int OPEN_T  = 4;
  localparam int CLEAR_T = 6;

  localparam int M_IDLE  = 0;
  localparam int M_NONE  = 1;
  localparam int M_LEFT  = 2;
  localparam int M_RIGHT = 3;
  localparam int M_CLEAR = 4;

  typedef struct {
    int mode;
    int remain;  // cycles left in the current interval, including this one
  } mstate_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic       arrive = 1'b0;
  logic [1:0] dutLoad;
  logic       dutCleared;
  logic [2:0] dutState;

  int vectors = 0;
  int miscompares = 0;

  mstate_t mS = '{0, 0};
  logic    mPrevL = 1'b0;
  logic    mPrevR = 1'b0;
  logic    mValid = 1'b0;

  sc_statemachine_entryfrogger #(
    .SC_STATEMACHINE_ENTRYFROGGER_COUNTWIDTH(24),
    .OPEN_TICKS(24'd4),
    .CLEAR_TICKS(24'd6)
  ) dut (
    .SC_STATEMACHINE_ENTRYFROGGER_CLOCK_50(clk),
    .SC_STATEMACHINE_ENTRYFROGGER_RESET_InHigh(rst),
    .SC_STATEMACHINE_ENTRYFROGGER_start_In(start),
    .SC_STATEMACHINE_ENTRYFROGGER_left_In(left),
    .SC_STATEMACHINE_ENTRYFROGGER_right_In(right),
    .SC_STATEMACHINE_ENTRYFROGGER_arrive_In(arrive),
    .SC_STATEMACHINE_ENTRYFROGGER_loadEntry_OutBUS(dutLoad),
    .SC_STATEMACHINE_ENTRYFROGGER_cleared_Out(dutCleared),
    .SC_STATEMACHINE_ENTRYFROGGER_state_OutBUS(dutState)
  );

  always #5 clk = ~clk;

  function automatic mstate_t nextModel(input mstate_t s, input logic lr, input logic rr,
                                        input logic st, input logic ar);
    mstate_t n;
    n = s;
    case (s.mode)
      M_IDLE: if (st) n = '{M_NONE, 0};
      M_NONE: begin
        if (ar)              n = '{M_CLEAR, CLEAR_T};
        else if (lr && !rr)  n = '{M_LEFT, OPEN_T};
        else if (rr && !lr)  n = '{M_RIGHT, OPEN_T};
      end
      M_LEFT, M_RIGHT: begin
        if (ar)                n = '{M_CLEAR, CLEAR_T};
        else if (lr && rr)     n = '{M_NONE, 0};
        else if (lr)           n = '{M_LEFT, OPEN_T};
        else if (rr)           n = '{M_RIGHT, OPEN_T};
        else if (s.remain == 1) n = '{M_NONE, 0};
        else                   n.remain = s.remain - 1;
      end
      default: begin
        if (s.remain == 1) n = '{M_NONE, 0};
        else               n.remain = s.remain - 1;
      end
    endcase
    return n;
  endfunction

  function automatic logic [1:0] loadOf(input int mode);
    case (mode)
      M_NONE:  return 2'b00;
      M_LEFT:  return 2'b10;
      M_RIGHT: return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mS     <= '{M_IDLE, 0};
      mPrevL <= 1'b0;
      mPrevR <= 1'b0;
      mValid <= 1'b1;
    end else begin
      mPrevL <= left;
      mPrevR <= right;
      mS     <= nextModel(mS, left && !mPrevL, right && !mPrevR, start, arrive);
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      logic [1:0] eLoad;
      logic [2:0] eState;
      logic       eClr;
      eLoad  = loadOf(mS.mode);
      eState = 3'(mS.mode);
      eClr   = (mS.mode == M_CLEAR) && (mS.remain == 1);
      vectors++;
      if (dutLoad !== eLoad || dutState !== eState || dutCleared !== eClr) begin
        miscompares++;
        $display("FAIL model @%0t: load=%b state=%b cleared=%b, required load=%b state=%b cleared=%b",
                 $time, dutLoad, dutState, dutCleared, eLoad, eState, eClr);
      end
    end
  end

  task automatic tick(input logic s, input logic l, input logic r, input logic a, input logic rs);
    start = s; left = l; right = r; arrive = a; rst = rs;
    @(negedge clk);
    #1;
  endtask

  task automatic expectLit(input string nm, input logic [1:0] eLoad, input logic [2:0] eState,
                           input logic eClr);
    vectors++;
    if (dutLoad !== eLoad || dutState !== eState || dutCleared !== eClr) begin
      miscompares++;
      $display("FAIL %s: load=%b state=%b cleared=%b, required load=%b state=%b cleared=%b",
               nm, dutLoad, dutState, dutCleared, eLoad, eState, eClr);
    end
  endtask

  initial begin
    logic s, l, r, a, rs;

    // Reset, then start
    tick(0, 0, 0, 0, 1); expectLit("reset1", 2'b11, 3'b000, 0);
    tick(0, 0, 0, 0, 1); expectLit("reset2", 2'b11, 3'b000, 0);
    tick(1, 0, 0, 0, 0); expectLit("start", 2'b00, 3'b001, 0);

    // Held left gives a single 4-cycle gap
    for (int k = 1; k <= 10; k++) begin
      tick(0, 1, 0, 0, 0);
      if (k <= 4) expectLit("left_held_open", 2'b10, 3'b010, 0);
      else        expectLit("left_held_closed", 2'b00, 3'b001, 0);
    end
    tick(0, 0, 0, 0, 0); expectLit("left_release", 2'b00, 3'b001, 0);

    // LEFT, switch to RIGHT at timer 2, extend RIGHT at timer 3
    tick(0, 1, 0, 0, 0); expectLit("left_t0", 2'b10, 3'b010, 0);
    tick(0, 0, 0, 0, 0); expectLit("left_t1", 2'b10, 3'b010, 0);
    tick(0, 0, 0, 0, 0); expectLit("left_t2", 2'b10, 3'b010, 0);
    tick(0, 0, 1, 0, 0); expectLit("right_t0", 2'b01, 3'b011, 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 0, 0, 0); expectLit("right_run", 2'b01, 3'b011, 0);
    end
    tick(0, 0, 1, 0, 0); expectLit("right_extend", 2'b01, 3'b011, 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 0, 0, 0); expectLit("right_ext_run", 2'b01, 3'b011, 0);
    end
    tick(0, 0, 0, 0, 0); expectLit("right_timeout", 2'b00, 3'b001, 0);

    // Simultaneous rises
    tick(0, 1, 1, 0, 0); expectLit("both_in_none", 2'b00, 3'b001, 0);
    tick(0, 0, 0, 0, 0); expectLit("both_release", 2'b00, 3'b001, 0);
    tick(0, 0, 1, 0, 0); expectLit("right_enter", 2'b01, 3'b011, 0);
    tick(0, 0, 0, 0, 0); expectLit("right_t1b", 2'b01, 3'b011, 0);
    tick(0, 1, 1, 0, 0); expectLit("both_in_right", 2'b00, 3'b001, 0);
    tick(0, 0, 0, 0, 0); expectLit("both_release2", 2'b00, 3'b001, 0);

    // Arrive beats a left rise; full clear interval
    tick(0, 1, 0, 1, 0); expectLit("clear_c1", 2'b11, 3'b100, 0);
    for (int k = 2; k <= 5; k++) begin
      tick(0, 0, 0, 0, 0); expectLit("clear_mid", 2'b11, 3'b100, 0);
    end
    tick(0, 0, 0, 0, 0); expectLit("clear_c6", 2'b11, 3'b100, 1);
    tick(0, 0, 0, 0, 0); expectLit("clear_done", 2'b00, 3'b001, 0);

    // Reset in CLEAR cycle 3 aborts without a pulse
    tick(0, 0, 0, 1, 0); expectLit("clear2_c1", 2'b11, 3'b100, 0);
    tick(0, 0, 0, 0, 0); expectLit("clear2_c2", 2'b11, 3'b100, 0);
    tick(0, 0, 0, 0, 0); expectLit("clear2_c3", 2'b11, 3'b100, 0);
    tick(0, 0, 0, 0, 1); expectLit("clear_abort", 2'b11, 3'b000, 0);
    for (int k = 0; k < 5; k++) begin
      tick(0, 0, 0, 0, 0); expectLit("idle_hold", 2'b11, 3'b000, 0);
    end

    // Randomized stimulus; the negedge compare process checks every cycle
    l = 1'b0;
    r = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      rs = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) l = ~l;
      if ($urandom_range(0, 3) == 0) r = ~r;
      a  = ($urandom_range(0, 19) == 0);
      tick(s, l, r, a, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sc_statemachine_entryfrogger.md
SC_STATEMACHINE_ENTRYFROGGER -- requirements
Module: SC_STATEMACHINE_ENTRYFROGGER

Interface
REQ-001 Parameter SC_STATEMACHINE_ENTRYFROGGER_COUNTWIDTH, default 24: timer width in bits.
REQ-002 Parameter OPEN_TICKS, default 24'd5000000: cycles an entry gap stays shifted left/right; legal range 1..2^COUNTWIDTH-1.
REQ-003 Parameter CLEAR_TICKS, default 24'd10000000: cycles the entry row stays cleared after a frog arrives; legal range 1..2^COUNTWIDTH-1.
REQ-004 SC_STATEMACHINE_ENTRYFROGGER_CLOCK_50  input  1  system clock; all state changes occur on its rising edge.
REQ-005 SC_STATEMACHINE_ENTRYFROGGER_RESET_InHigh  input  1  reset, synchronous, active-high.
REQ-006 SC_STATEMACHINE_ENTRYFROGGER_start_In  input  1  level; start game from IDLE.
REQ-007 SC_STATEMACHINE_ENTRYFROGGER_left_In  input  1  debounced level button; rising edge requests a left-shifted gap.
REQ-008 SC_STATEMACHINE_ENTRYFROGGER_right_In  input  1  debounced level button; rising edge requests a right-shifted gap.
REQ-009 SC_STATEMACHINE_ENTRYFROGGER_arrive_In  input  1  level; frog has reached the entry row.
REQ-010 SC_STATEMACHINE_ENTRYFROGGER_loadEntry_OutBUS  output  2  entry-register select: 00 none, 01 right, 10 left, 11 clear.
REQ-011 SC_STATEMACHINE_ENTRYFROGGER_cleared_Out  output  1  one-cycle pulse at end of the clear interval.
REQ-012 SC_STATEMACHINE_ENTRYFROGGER_state_OutBUS  output  3  current state code (debug): IDLE 000, NONE 001, LEFT 010, RIGHT 011, CLEAR 100.

Function
REQ-013 The block SHALL register left_In and right_In each cycle; rise = current & ~previous; no other input is edge-detected.
REQ-014 loadEntry_OutBUS SHALL be a Moore decode of the state register: IDLE 11, NONE 00, LEFT 10, RIGHT 01, CLEAR 11.
REQ-015 IDLE: start_In=1 -> NONE next cycle; all other inputs are ignored.
REQ-016 NONE: priority arrive_In -> CLEAR; else left rise only -> LEFT; else right rise only -> RIGHT; both rises in the same cycle, or no rise -> stay NONE.
REQ-017 LEFT/RIGHT: arrive_In -> CLEAR (highest priority); rise of the opposite button -> opposite state with timer restarted at 0; rise of the same button -> timer restarted at 0, state kept; both rises -> NONE.
REQ-018 LEFT/RIGHT timeout: with no higher-priority event, timer == OPEN_TICKS-1 -> NONE, so an unextended gap lasts exactly OPEN_TICKS cycles.
REQ-019 CLEAR: button and arrive inputs are ignored; timer == CLEAR_TICKS-1 -> NONE, so the clear lasts exactly CLEAR_TICKS cycles.
REQ-020 cleared_Out SHALL be 1 only in the last CLEAR cycle (the cycle in which timer == CLEAR_TICKS-1), otherwise 0.
REQ-021 Timer: 0 on every state entry or restart, +1 per cycle while in LEFT/RIGHT/CLEAR, held at 0 in IDLE/NONE, and never wraps because of REQ-018/019.
REQ-022 An undefined state code SHALL return to IDLE on the next cycle.

Reset
REQ-023 RESET_InHigh=1 at a clock edge SHALL force state IDLE, timer 0, edge registers 0, cleared_Out 0, loadEntry_OutBUS 11, state_OutBUS 000, overriding every other input.
REQ-024 Reset asserted mid-LEFT/RIGHT/CLEAR SHALL abort the interval with no cleared_Out pulse; after release, NONE is reached only via start_In.

Verification (OPEN_TICKS=4, CLEAR_TICKS=6)
REQ-025 Reset 2 cycles, then start_In=1 for 1 cycle -> loadEntry 11 during reset, 00 in the next cycle, state 001.
REQ-026 In NONE, left_In held high 10 cycles -> loadEntry 10 for exactly 4 cycles, then 00 (held level gives one rise only).
REQ-027 In LEFT at timer=2, right rise -> loadEntry 01 for 4 full cycles; right rise again at timer=3 -> RIGHT extended by another 4 cycles.
REQ-028 In NONE, left and right rise in the same cycle -> stays 00; in RIGHT, the same -> 00 next cycle.
REQ-029 arrive_In=1 in the same cycle as a left rise -> CLEAR, loadEntry 11 for 6 cycles, cleared_Out=1 in the 6th cycle only, then 00.
REQ-030 Reset at CLEAR cycle 3 -> IDLE, loadEntry 11, no cleared_Out pulse; with start_In=0, the block stays in IDLE.
